// File: rtl/uart_tx.sv
// UART transmitter: one parallel word per valid/ready handshake, sent as
// start bit, LSB-first data, optional parity and stop bit(s) on uart_out.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 uart_out
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par, par_n;
  logic                 out_n, rdy_n, done_n;
  logic                 bit_end;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
  assign tx_busy = ~tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      par      <= 1'b0;
      uart_out <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sh       <= sh_n;
      par      <= par_n;
      uart_out <= out_n;
      tx_ready <= rdy_n;
      tx_done  <= done_n;
    end
  end

  // Every output is registered, so each branch decides the value the line
  // will carry during the next cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    out_n   = uart_out;
    rdy_n   = tx_ready;
    done_n  = 1'b0;
    if (state != IDLE)
      cnt_n = bit_end ? '0 : cnt + CW'(1);
    case (state)
      IDLE: begin
        if (tx_valid) begin
          sh_n    = tx_data;
          par_n   = (PARITY == 2) ? ~(^tx_data) : ^tx_data;
          state_n = START;
          out_n   = 1'b0;
          rdy_n   = 1'b0;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          out_n   = sh[0];
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_n = sh >> 1;
          if (idx == 3'(DATA_BITS - 1)) begin
            idx_n = '0;
            if (PARITY != 0) begin
              state_n = PAR;
              out_n   = par;
            end else begin
              state_n = STOP;
              out_n   = 1'b1;
            end
          end else begin
            idx_n = idx + 3'd1;
            out_n = sh[1];
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_n = STOP;
          out_n   = 1'b1;
          idx_n   = '0;
        end
      end
      STOP: begin
        // Raise done one cycle early so the registered pulse lands on the
        // final stop cycle.
        if (idx == 3'(STOP_BITS - 1) && cnt == CW'(CLKS_PER_BIT - 2))
          done_n = 1'b1;
        if (bit_end) begin
          if (idx == 3'(STOP_BITS - 1)) begin
            state_n = IDLE;
            rdy_n   = 1'b1;
            idx_n   = '0;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        out_n   = 1'b1;
        rdy_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: three instances (no/even/odd parity) with
// a serial-line monitor per instance that decodes and checks each frame.
module tb_uart_tx;

  localparam int C = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       has_par;
    logic       par;
    logic       abort;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] tv = '0;
  logic [7:0] td [3];
  logic [2:0] uo, rdy, bsy, dn;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  frame_t sbq [3][$];
  int     start_log [3][$];
  bit     mon_busy [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) d0 (
    .clk(clk), .rst(rst), .tx_data(td[0]), .tx_valid(tv[0]), .tx_ready(rdy[0]),
    .tx_busy(bsy[0]), .tx_done(dn[0]), .uart_out(uo[0]));
  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) d1 (
    .clk(clk), .rst(rst), .tx_data(td[1]), .tx_valid(tv[1]), .tx_ready(rdy[1]),
    .tx_busy(bsy[1]), .tx_done(dn[1]), .uart_out(uo[1]));
  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) d2 (
    .clk(clk), .rst(rst), .tx_data(td[2]), .tx_valid(tv[2]), .tx_ready(rdy[2]),
    .tx_busy(bsy[2]), .tx_done(dn[2]), .uart_out(uo[2]));

  function automatic logic exp_bit(frame_t f, int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return f.data[b-1];
    if (f.has_par && b == 9) return f.par;
    return 1'b1;
  endfunction

  task automatic monitor(input int id);
    frame_t     f;
    int         len, bad_bits, ctl_bad;
    bit         aborted;
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (!rst && uo[id] === 1'b0) begin
        mon_busy[id] = 1'b1;
        start_log[id].push_back(cyc);
        if (sbq[id].size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame dut%0d: start bit at cycle %0d, required none", id, cyc);
          repeat (11*C) @(negedge clk);
        end else begin
          f = sbq[id].pop_front();
          len = (10 + int'(f.has_par)) * C;
          bad_bits = 0; ctl_bad = 0; aborted = 1'b0; rx = '0;
          for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            if (uo[id] !== exp_bit(f, k / C)) bad_bits++;
            if (k / C >= 1 && k / C <= 8 && k % C == C / 2) rx[k/C-1] = uo[id];
            if (dn[id] !== (k == len - 1)) ctl_bad++;
            if (rdy[id] !== 1'b0 || bsy[id] !== 1'b1) ctl_bad++;
            if (rst) begin aborted = 1'b1; break; end
          end
          total++;
          if (aborted != f.abort || bad_bits != 0) begin
            bad++;
            $display("FAIL frame_bits dut%0d: got data=%h bad_cycles=%0d aborted=%0d, required data=%h bad_cycles=0 aborted=%0d",
                     id, rx, bad_bits, aborted, f.data, f.abort);
          end
          total++;
          if (ctl_bad != 0) begin
            bad++;
            $display("FAIL frame_ctrl dut%0d: %0d cycles with wrong tx_done/tx_ready/tx_busy, required 0", id, ctl_bad);
          end
          @(negedge clk);
          total++;
          if (uo[id] !== 1'b1 || rdy[id] !== 1'b1 || dn[id] !== 1'b0) begin
            bad++;
            $display("FAIL after_frame dut%0d: line=%b ready=%b done=%b, required 1 1 0", id, uo[id], rdy[id], dn[id]);
          end
        end
        mon_busy[id] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int id);
    int n = 0;
    while ((sbq[id].size() != 0 || mon_busy[id]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL timeout dut%0d: frame not finished after %0d cycles, required < 300", id, n);
    end
  endtask

  task automatic send(input int id, input logic [7:0] d, input logic hp,
                      input logic p, input logic ab, output int acc);
    @(posedge clk); #1;
    total++;
    if (rdy[id] !== 1'b1) begin
      bad++;
      $display("FAIL ready_before dut%0d: got %b required 1", id, rdy[id]);
    end
    sbq[id].push_back('{data: d, has_par: hp, par: p, abort: ab});
    td[id] = d;
    tv[id] = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    tv[id] = 1'b0;
    total++;
    if (rdy[id] !== 1'b0 || uo[id] !== 1'b0) begin
      bad++;
      $display("FAIL accept_edge dut%0d: ready=%b line=%b, required 0 0", id, rdy[id], uo[id]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n;
    for (int i = 0; i < 3; i++) td[i] = '0;
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    // reset state, then 20 idle cycles
    repeat (4) begin
      @(negedge clk);
      if (cyc > 0) begin
        total++;
        if (uo !== 3'b111 || rdy !== 3'b111 || bsy !== 3'b000 || dn !== 3'b000) begin
          bad++;
          $display("FAIL reset_state: line=%b ready=%b busy=%b done=%b, required 111 111 000 000", uo, rdy, bsy, dn);
        end
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      total++;
      if (uo !== 3'b111 || rdy !== 3'b111 || bsy !== 3'b000 || dn !== 3'b000) begin
        bad++;
        $display("FAIL idle_state: line=%b ready=%b busy=%b done=%b, required 111 111 000 000", uo, rdy, bsy, dn);
      end
    end

    // single frame, start bit one cycle after accept
    start_log[0].delete();
    send(0, 8'hA5, 1'b0, 1'b0, 1'b0, acc);
    wait_idle(0);
    total++;
    if (start_log[0].size() != 1 || start_log[0][0] != acc) begin
      bad++;
      $display("FAIL start_latency: got start cycle %0d, required %0d",
               (start_log[0].size() > 0) ? start_log[0][0] : -1, acc);
    end

    // parity: 07 even ->1, 00 even ->0, 07 odd ->0
    send(1, 8'h07, 1'b1, 1'b1, 1'b0, acc);
    wait_idle(1);
    send(1, 8'h00, 1'b1, 1'b0, 1'b0, acc);
    wait_idle(1);
    send(2, 8'h07, 1'b1, 1'b0, 1'b0, acc);
    wait_idle(2);

    // back-to-back with tx_valid held high; data changes mid-frame
    start_log[0].delete();
    sbq[0].push_back('{data: 8'h55, has_par: 1'b0, par: 1'b0, abort: 1'b0});
    sbq[0].push_back('{data: 8'h0F, has_par: 1'b0, par: 1'b0, abort: 1'b0});
    @(posedge clk); #1;
    td[0] = 8'h55; tv[0] = 1'b1;
    @(posedge clk); #1;
    td[0] = 8'h0F;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rdy[0] !== 1'b1 && n < 100);
    @(posedge clk); #1;
    tv[0] = 1'b0;
    wait_idle(0);
    total++;
    if (start_log[0].size() != 2 || start_log[0][1] - start_log[0][0] != 41) begin
      bad++;
      $display("FAIL b2b_gap: got %0d starts spacing %0d, required 2 starts spacing 41", start_log[0].size(),
               (start_log[0].size() == 2) ? start_log[0][1] - start_log[0][0] : -1);
    end

    // tx_valid while busy is dropped
    send(0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
    repeat (10) @(posedge clk);
    #1 td[0] = 8'hFF; tv[0] = 1'b1;
    @(posedge clk); #1 tv[0] = 1'b0;
    wait_idle(0);
    repeat (50) @(negedge clk);

    // reset during data bit 3 (cycle 18 of the frame)
    send(0, 8'hF0, 1'b0, 1'b0, 1'b1, acc);
    repeat (17) @(posedge clk);
    #1;
    total++;
    if (uo[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_setup: line=%b in data bit 3 of F0, required 0", uo[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (uo[0] !== 1'b1 || rdy[0] !== 1'b1 || dn[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_edge: line=%b ready=%b done=%b, required 1 1 0", uo[0], rdy[0], dn[0]);
    end
    wait_idle(0);
    send(0, 8'h3C, 1'b0, 1'b0, 1'b0, acc);
    wait_idle(0);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      total++;
      if (sbq[i].size() != 0 || mon_busy[i]) begin
        bad++;
        $display("FAIL scoreboard_empty dut%0d: %0d frames pending, required 0", i, sbq[i].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter. It is the sending counterpart of the existing `uart` receiver block, which samples `uart_in`.
- It accepts one parallel byte per valid/ready handshake from the CPU-side I/O logic. It shifts the byte out as an asynchronous frame on `uart_out`: start bit, data bits LSB first, optional parity, then stop bit(s).
- In the testbench, `uart_out` can be looped directly onto the receiver's `uart_in`.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per bit period. Must be ≥2.
- DATA_BITS, 8: data bits per frame. Range 5..8.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bit periods. Must be 1 or 2.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to send. Sampled only on the accept cycle.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  transmitter idle and able to accept.
- tx_busy  output  1  a frame is in progress.
- tx_done  output  1  one-cycle pulse in the last cycle of the final stop bit.
- uart_out  output  1  serial line. Idles high.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state = IDLE, uart_out = 1, tx_ready = 1, tx_busy = 0, tx_done = 0.
  - Bit counter, baud counter and shift register are cleared.
  - Reset mid-frame aborts the frame. uart_out returns high at that same edge, with no partial stop bit.
- Accept: when state == IDLE, tx_valid == 1 and rst == 0 at a rising edge:
  - tx_data is latched into the shift register.
  - The parity bit is computed from the latched data. Even parity = XOR of the data bits; odd parity = its inverse.
  - state -> START.
  - tx_valid is ignored whenever tx_ready == 0; nothing is queued.
  - tx_data changes after the accept edge have no effect on the current frame.
- Outputs are registered:
  - uart_out goes 0 at the accept edge, so the start bit begins on the cycle after accept (latency 1 clock).
  - tx_ready is 1 only in IDLE. It drops at the accept edge.
  - tx_busy = ~tx_ready.
- States; each bit is held for exactly CLKS_PER_BIT cycles by a baud counter that counts 0..CLKS_PER_BIT-1:
  - IDLE: uart_out = 1.
  - START: uart_out = 0 for one bit period, then DATA with bit index 0.
  - DATA: uart_out = shift register bit 0. At the end of each bit period, shift right and increment the index. After index DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
  - PARITY: uart_out = parity bit for one bit period, then STOP.
  - STOP: uart_out = 1 for STOP_BITS × CLKS_PER_BIT cycles. In the last STOP cycle, tx_done = 1. At the following edge, state = IDLE and tx_ready = 1.
- Frame length from the first start cycle to the end of the last stop cycle: CLKS_PER_BIT × (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles.
- Back-to-back transfers:
  - Minimum one IDLE cycle (line high) between frames.
  - If tx_valid is held high, the next accept occurs in that IDLE cycle. Consecutive frames are therefore separated by exactly one extra high cycle.
- tx_done is 0 in every other cycle, including the reset cycle and the abort cycle.
- No glitches: uart_out changes only on baud-counter boundaries and at the accept and reset edges.

Test Plan:
- Idle after reset (CLKS_PER_BIT=4): hold rst=1 for 4 cycles, then release and wait 20 cycles with tx_valid=0 -> uart_out=1, tx_ready=1, tx_busy=0 and tx_done=0 throughout.
- Single frame (CLKS_PER_BIT=4, PARITY=0, tx_data=8'hA5, one-cycle valid) -> starting the cycle after accept, uart_out shows 0 followed by 1,0,1,0,0,1,0,1 then 1, each held 4 cycles (40 cycles total). tx_done pulses in cycle 40. tx_ready returns at cycle 41.
- Parity (CLKS_PER_BIT=4):
  - 8'h07 with PARITY=1 -> parity bit 1.
  - 8'h07 with PARITY=2 -> parity bit 0.
  - 8'h00 with PARITY=1 -> parity bit 0.
  - Each frame is 44 cycles.
- Back-to-back: tx_valid held high with tx_data=8'h55, then 8'h0F -> two frames separated by exactly one high IDLE cycle. Changing tx_data mid-frame does not alter the first frame. Loopback into the `uart` receiver yields 8'h55, then 8'h0F.
- Busy ignore and reset abort:
  - Pulse tx_valid with 8'hFF during a frame of 8'h00 -> 8'hFF is never sent.
  - Assert rst during data bit 3 -> uart_out=1 and tx_ready=1 at that edge, with no tx_done pulse.
  - A new frame sent after rst is released is correct.
